fpu_host_seq: RTL and testbench
===============================

Name: fpu_host_seq

Overview:
- Bus-master sequencer that sits directly upstream of the byte-wide memory-mapped FPU.
- Accepts a 32-bit Y/X operand pair plus an op select in one start pulse.
- Drives the FPU's select/addr/read/write/data lines to load the operands, issue the command, poll status and read back the 32-bit result.
- Lets a controller or test harness use the FPU without firmware byte-banging.

Parameters:
- TIMEOUT, 255, maximum status polls before abort; used only with FPU_SEQ_TIMEOUT_EN.
- CNT_W, 8, width of the poll counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  1  0 = divide (Y/X, FPU cmd 3), 1 = multiply (Y*X, FPU cmd 4)
- y_in  in  32  IEEE-754 single Y operand, captured on accepted start
- x_in  in  32  IEEE-754 single X operand, captured on accepted start
- busy  out  1  high from accepted start until the done pulse (inclusive)
- done  out  1  one-cycle pulse; result valid from this cycle
- result  out  32  last FPU result, held until the next done
- err  out  1  timeout flag; exists only with FPU_SEQ_TIMEOUT_EN
- fpusel  out  1  FPU chip select, high during every strobe
- addr  out  2  00 status, 01 result read, 10 command write, 11 value write
- read  out  1  read strobe
- write  out  1  write strobe
- wdata  out  8  command code or operand byte
- rdata  in  8  FPU dataout, combinational while read is high

Behaviour:
- Reset values: busy=0, done=0, result=0, err=0, fpusel=0, addr=00, read=0, write=0, wdata=0, state=IDLE.
- Async reset mid-operation aborts immediately, with no partial result and no done.
- Strobe rule: every bus access is one strobe cycle followed by one gap cycle with fpusel/read/write low. The gap is mandatory: the FPU detects command writes on a rising edge and advances byte indices on a falling edge.
- addr and wdata are stable for the whole strobe cycle.
- Byte order is MSB first: [31:24], [23:16], [15:8], [7:0].
- States and transitions:
  - IDLE: start → capture y_in, x_in, op; busy=1; go to CMD_Y.
  - CMD_Y: write addr=10, wdata=1.
  - VAL_Y: 4 strobes, addr=11, Y bytes in order.
  - CMD_X: write addr=10, wdata=2.
  - VAL_X: 4 strobes, addr=11, X bytes in order.
  - CMD_OP: write addr=10, wdata = op ? 4 : 3.
  - POLL: read addr=00; rdata[7]=1 → another poll after the gap; rdata[7]=0 → SETTLE.
  - SETTLE: one idle cycle, because the FPU latches its result register one cycle after clearing busy.
  - RD: 4 strobes, addr=01; rdata is sampled in each strobe cycle into a shift register.
  - DONE: result ← assembled word; done=1; busy=0 the following cycle; return to IDLE.
- A 2-bit byte index shares VAL_Y/VAL_X/RD and wraps 3→0 on each phase exit.
- Load phase is fixed at 22 cycles (11 strobes × 2), start-accept edge to end of CMD_OP gap.
- Total latency = 22 + 2·polls + 1 + 8 + 1 cycles.
- Simultaneous events: start while busy is ignored with no queueing. start in the same cycle as done is ignored.
- rdata is ignored in non-read cycles.

Optional Feature:
- FPU_SEQ_TIMEOUT_EN defined:
  - POLL counts polls. After TIMEOUT consecutive busy polls, go to IDLE, set err=1, pulse done, leave result unchanged.
  - err clears on the next accepted start.
- Not defined: POLL waits indefinitely. err port and poll counter are absent.

Decomposition:
- Shared package fpu_pkg holds:
  - address constants FPU_ADDR_STATUS/RESULT/CMD/VALUE
  - command codes FPU_CMD_SETY=1, SETX=2, DIV=3, MUL=4
  - status busy-bit index 7
  - sequencer state enum
- One natural sub-module, fpu_bus_strobe, generates the strobe/gap pair and a strobe_done pulse from a request plus addr/wdata/rd_nwr.

Test Plan:
- Divide, y_in=0x40C00000 (6.0), x_in=0x40000000 (2.0), op=0 → bus trace is exactly write(10,01), writes 40,C0,00,00, write(10,02), writes 40,00,00,00, write(10,03); result=0x40400000 (3.0).
- Multiply, y_in=0x3FC00000 (1.5), x_in=0x40000000 (2.0), op=1 → cmd byte 04; result=0x40400000.
- Protocol monitor, any op → no two strobes in consecutive cycles; read and write never both high; fpusel high exactly when a strobe is high.
- FPU model returning status busy for 5 polls → exactly 5+1 status reads, one SETTLE cycle, then 4 result reads; done at cycle 22+12+1+8+1.
- rst_n low during VAL_X byte 2 → all bus outputs 0 asynchronously, busy=0; next start replays from CMD_Y.
- Second start pulse during POLL → ignored, single done. With FPU_SEQ_TIMEOUT_EN, TIMEOUT=4, rdata stuck 0x80 → err=1 with done after 4 polls, result unchanged.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU bus constants, command codes and sequencer state type
package fpu_pkg;

    localparam logic [1:0] FPU_ADDR_STATUS = 2'b00;
    localparam logic [1:0] FPU_ADDR_RESULT = 2'b01;
    localparam logic [1:0] FPU_ADDR_CMD    = 2'b10;
    localparam logic [1:0] FPU_ADDR_VALUE  = 2'b11;

    localparam logic [7:0] FPU_CMD_SETY = 8'd1;
    localparam logic [7:0] FPU_CMD_SETX = 8'd2;
    localparam logic [7:0] FPU_CMD_DIV  = 8'd3;
    localparam logic [7:0] FPU_CMD_MUL  = 8'd4;

    localparam int FPU_STATUS_BUSY_BIT = 7;

    typedef enum logic [3:0] {
        SEQ_IDLE,
        SEQ_CMD_Y,
        SEQ_VAL_Y,
        SEQ_CMD_X,
        SEQ_VAL_X,
        SEQ_CMD_OP,
        SEQ_POLL,
        SEQ_SETTLE,
        SEQ_RD,
        SEQ_DONE
    } seq_state_t;

    // Operand bytes go out MSB first, so index 0 selects [31:24].
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/fpu_bus_strobe.sv
// rtl/fpu_bus_strobe.sv - one-cycle bus strobe followed by a mandatory gap cycle
module fpu_bus_strobe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rd_nwr,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       strobe_done,
    output logic       fpusel,
    output logic [1:0] addr,
    output logic       read,
    output logic       write,
    output logic [7:0] wdata
);

    logic gap;
    logic strobe;

    // The FPU needs the low gap to see fresh command edges and byte-index advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap <= 1'b0;
        end else begin
            gap <= req & ~gap;
        end
    end

    assign strobe      = req & ~gap;
    assign strobe_done = gap;
    assign fpusel      = strobe;
    assign read        = strobe & rd_nwr;
    assign write       = strobe & ~rd_nwr;
    assign addr        = strobe ? req_addr : 2'b00;
    assign wdata       = (strobe & ~rd_nwr) ? req_wdata : 8'h00;

endmodule

// File: rtl/fpu_host_seq.sv
// rtl/fpu_host_seq.sv - bus-master sequencer driving a byte-wide FPU (optional FPU_SEQ_TIMEOUT_EN)
module fpu_host_seq
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] y_in,
    input  logic [31:0] x_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
`ifdef FPU_SEQ_TIMEOUT_EN
    output logic        err,
`endif
    output logic        fpusel,
    output logic [1:0]  addr,
    output logic        read,
    output logic        write,
    output logic [7:0]  wdata,
    input  logic [7:0]  rdata
);

    if ((2 ** CNT_W) <= TIMEOUT) begin : g_bad_cnt_w
        $error("fpu_host_seq: CNT_W too narrow for TIMEOUT");
    end

    seq_state_t  state, state_next;
    logic [31:0] y_reg, x_reg, shreg;
    logic        op_reg;
    logic [1:0]  idx;
    logic        poll_busy;
    logic        timeout_hit;
    logic        req, rd_nwr, strobe_done;
    logic [1:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        last_byte;

    assign last_byte = strobe_done && (idx == 2'd3);

    fpu_bus_strobe u_strobe (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .rd_nwr      (rd_nwr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .strobe_done (strobe_done),
        .fpusel      (fpusel),
        .addr        (addr),
        .read        (read),
        .write       (write),
        .wdata       (wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req        = 1'b0;
        rd_nwr     = 1'b0;
        req_addr   = FPU_ADDR_CMD;
        req_wdata  = 8'h00;
        case (state)
            SEQ_IDLE: if (start) state_next = SEQ_CMD_Y;
            SEQ_CMD_Y: begin
                req       = 1'b1;
                req_wdata = FPU_CMD_SETY;
                if (strobe_done) state_next = SEQ_VAL_Y;
            end
            SEQ_VAL_Y: begin
                req       = 1'b1;
                req_addr  = FPU_ADDR_VALUE;
                req_wdata = word_byte(y_reg, idx);
                if (last_byte) state_next = SEQ_CMD_X;
            end
            SEQ_CMD_X: begin
                req       = 1'b1;
                req_wdata = FPU_CMD_SETX;
                if (strobe_done) state_next = SEQ_VAL_X;
            end
            SEQ_VAL_X: begin
                req       = 1'b1;
                req_addr  = FPU_ADDR_VALUE;
                req_wdata = word_byte(x_reg, idx);
                if (last_byte) state_next = SEQ_CMD_OP;
            end
            SEQ_CMD_OP: begin
                req       = 1'b1;
                req_wdata = op_reg ? FPU_CMD_MUL : FPU_CMD_DIV;
                if (strobe_done) state_next = SEQ_POLL;
            end
            SEQ_POLL: begin
                req      = 1'b1;
                rd_nwr   = 1'b1;
                req_addr = FPU_ADDR_STATUS;
                if (strobe_done) begin
                    if (!poll_busy)       state_next = SEQ_SETTLE;
                    else if (timeout_hit) state_next = SEQ_DONE;
                end
            end
            // The FPU updates its result register one cycle after dropping busy.
            SEQ_SETTLE: state_next = SEQ_RD;
            SEQ_RD: begin
                req      = 1'b1;
                rd_nwr   = 1'b1;
                req_addr = FPU_ADDR_RESULT;
                if (last_byte) state_next = SEQ_DONE;
            end
            SEQ_DONE: state_next = SEQ_IDLE;
            default:  state_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg     <= '0;
            x_reg     <= '0;
            op_reg    <= 1'b0;
            idx       <= 2'd0;
            poll_busy <= 1'b0;
            shreg     <= '0;
            result    <= '0;
        end else begin
            if (state == SEQ_IDLE && start) begin
                y_reg  <= y_in;
                x_reg  <= x_in;
                op_reg <= op;
            end
            if (strobe_done && (state == SEQ_VAL_Y || state == SEQ_VAL_X || state == SEQ_RD))
                idx <= idx + 2'd1;
            if (read && state == SEQ_POLL)
                poll_busy <= rdata[FPU_STATUS_BUSY_BIT];
            if (read && state == SEQ_RD)
                shreg <= {shreg[23:0], rdata};
            if (state == SEQ_RD && last_byte)
                result <= shreg;
        end
    end

`ifdef FPU_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] poll_cnt;

    assign timeout_hit = poll_busy && (poll_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= '0;
            err      <= 1'b0;
        end else if (state == SEQ_IDLE && start) begin
            poll_cnt <= '0;
            err      <= 1'b0;
        end else if (state == SEQ_POLL && strobe_done && poll_busy) begin
            if (timeout_hit) err <= 1'b1;
            else             poll_cnt <= poll_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign busy = (state != SEQ_IDLE);
    assign done = (state == SEQ_DONE);

endmodule

// File: tb/tb_fpu_host_seq.sv
// tb/tb_fpu_host_seq.sv - randomized self-checking bench with FPU bus model and trace scoreboard
module tb_fpu_host_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] y_in = '0;
    logic [31:0] x_in = '0;
    logic        busy, done, err;
    logic [31:0] result;
    logic        fpusel, read, write;
    logic [1:0]  addr;
    logic [7:0]  wdata, rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int TMO = 4;
    localparam int MAXP = 3;
    fpu_host_seq #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .y_in(y_in), .x_in(x_in),
        .busy(busy), .done(done), .result(result), .err(err),
        .fpusel(fpusel), .addr(addr), .read(read), .write(write), .wdata(wdata), .rdata(rdata));
`else
    localparam int TMO = 255;
    localparam int MAXP = 6;
    assign err = 1'b0;
    fpu_host_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .y_in(y_in), .x_in(x_in),
        .busy(busy), .done(done), .result(result),
        .fpusel(fpusel), .addr(addr), .read(read), .write(write), .wdata(wdata), .rdata(rdata));
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FPU model: busy for busy_polls status reads, then serves fpu_res MSB first.
    int          busy_polls = 0;
    int          status_reads = 0, result_reads = 0;
    int          poll_base = 0, res_base = 0;
    logic [31:0] fpu_res = '0;
    logic [7:0]  noise = 8'h00;
    logic [31:0] rtmp;

    always @(posedge clk) begin
        noise <= 8'($urandom);
        if (read && addr == 2'b00) status_reads <= status_reads + 1;
        if (read && addr == 2'b01) result_reads <= result_reads + 1;
    end

    always_comb begin
        rtmp  = fpu_res << (8 * ((result_reads - res_base) % 4));
        rdata = noise;
        if (read && addr == 2'b00)
            rdata = {((status_reads - poll_base) < busy_polls), noise[6:0]};
        else if (read && addr == 2'b01)
            rdata = rtmp[31:24];
    end

    // Protocol monitor and bus-trace recorder: {read, addr, data}.
    logic [10:0] obs[$];
    logic [10:0] exp_q[$];
    logic        prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("protocol", {29'd0, fpusel ^ (read | write), read & write, prev_strobe & fpusel}, 32'd0);
            if (fpusel)
                obs.push_back({read, addr, read ? (addr == 2'b00 ? (rdata & 8'h80) : rdata) : wdata});
        end
        prev_strobe = rst_n & (fpusel | read | write);
    end

    logic [31:0] last_res = '0;

    task automatic run_txn(input logic op_v, input logic [31:0] y, input logic [31:0] x,
                           input logic [31:0] res, input int p, input int extra_cyc,
                           input bit start_at_done, input bit tmo);
        int lat, exp_lat, nstat;
        logic [31:0] exp_res;
        busy_polls = p;
        fpu_res    = res;
        poll_base  = status_reads;
        res_base   = result_reads;
        obs.delete();
        exp_q.delete();
        nstat   = tmo ? TMO : p + 1;
        exp_lat = tmo ? 22 + 2 * TMO + 1 : 22 + 2 * (p + 1) + 10;
        exp_res = tmo ? last_res : res;
        exp_q.push_back({3'b010, 8'd1});
        for (int i = 0; i < 4; i++) exp_q.push_back({3'b011, 8'(y >> (24 - 8 * i))});
        exp_q.push_back({3'b010, 8'd2});
        for (int i = 0; i < 4; i++) exp_q.push_back({3'b011, 8'(x >> (24 - 8 * i))});
        exp_q.push_back({3'b010, op_v ? 8'd4 : 8'd3});
        for (int i = 0; i < nstat; i++) exp_q.push_back({3'b100, (i < p) ? 8'h80 : 8'h00});
        if (!tmo)
            for (int i = 0; i < 4; i++) exp_q.push_back({3'b101, 8'(res >> (24 - 8 * i))});

        @(negedge clk);
        start = 1'b1; op = op_v; y_in = y; x_in = x;
        @(posedge clk);
        #1 start = 1'b0; op = ~op_v; y_in = $urandom; x_in = $urandom;
        lat = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            start = (c == extra_cyc);
            if (c == 1) chk("busy_after_start", {31'd0, busy}, 32'd1);
            if (done) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
        chk("latency", lat, exp_lat);
        chk("result", result, exp_res);
        chk("busy_at_done", {31'd0, busy}, 32'd1);
`ifdef FPU_SEQ_TIMEOUT_EN
        chk("err", {31'd0, err}, {31'd0, tmo});
`endif
        chk("trace_len", obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            chk($sformatf("trace[%0d]", i), {21'd0, obs[i]}, {21'd0, exp_q[i]});
        start = start_at_done;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_done", {30'd0, busy, done}, 32'd0);
        begin
            int extra_done = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                extra_done += int'(done) + int'(busy);
            end
            chk("single_done", extra_done, 0);
        end
        last_res = exp_res;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_out", {busy, done, fpusel, read, write, addr, wdata}, 32'd0);
        chk("reset_result", result, 32'd0);
`ifdef FPU_SEQ_TIMEOUT_EN
        chk("reset_err", {31'd0, err}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 1'b0, 1'b0);
        run_txn(1'b1, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 2, 0, 1'b0, 1'b0);
`ifndef FPU_SEQ_TIMEOUT_EN
        run_txn(1'b0, 32'h4120_0000, 32'h40A0_0000, 32'h4000_0000, 5, 0, 1'b0, 1'b0);
`endif
        run_txn(1'b1, $urandom, $urandom, $urandom, 3, 25, 1'b1, 1'b0);

        // Abort during VAL_X byte 2 (strobe in cycle 17), then replay.
        @(negedge clk);
        start = 1'b1; op = 1'b0; y_in = 32'h1122_3344; x_in = 32'h5566_7788;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_reset_byte", {24'd0, wdata}, 32'h77);
        rst_n = 1'b0;
        #1;
        chk("async_reset_bus", {busy, done, fpusel, read, write, addr, wdata}, 32'd0);
        chk("async_reset_result", result, 32'd0);
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 32'h1122_3344, 32'h5566_7788, 32'hCAFE_F00D, 1, 0, 1'b0, 1'b0);

        for (int n = 0; n < 12; n++)
            run_txn(1'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, MAXP)), 0, 1'($urandom), 1'b0);

`ifdef FPU_SEQ_TIMEOUT_EN
        run_txn(1'b0, $urandom, $urandom, $urandom, 100, 0, 1'b0, 1'b1);
        run_txn(1'b1, $urandom, $urandom, $urandom, 1, 0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
